interrupt_ack_responder: RTL and testbench

Glue-logic responder for the 68000 interrupt-acknowledge (IACK) bus cycle. It sits between the CPU bus and the seven active-low interrupt request lines that are also fed to the interrupt priority encoder.
- It decodes the CPU-space IACK cycle and strobes the acknowledged level's per-level IACK line.
- It answers the CPU with either an autovector (VPA) or a vector byte plus DTACK after a configurable wait.
- It substitutes the spurious-interrupt vector when the acknowledged level is no longer requesting.

---
 rtl/interrupt_ack_responder.sv | 148 ++++++++++++++
 tb/tb_interrupt_ack_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_ack_responder.sv
// 68000 IACK cycle responder: decodes the CPU-space acknowledge, strobes the per-level iack_n line
// and answers with autovector (vpa_n) or vector byte + dtack_n after WAIT_CYCLES. All outputs registered.
module interrupt_ack_responder #(
    parameter logic [6:0]  AUTOVEC_MASK = 7'b1111111,
    parameter logic [7:0]  VECTOR_BASE  = 8'h40,
    parameter int unsigned WAIT_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       as_n_i,
    input  logic [2:0] fc_i,
    input  logic [3:0] addr_hi_i,
    input  logic [2:0] addr_lo_i,
    input  logic [6:0] irq_n_i,
    output logic [6:0] iack_n_o,
    output logic       vpa_n_o,
    output logic       dtack_n_o,
    output logic [7:0] vec_out_o,
    output logic       vec_oe_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_WAIT,
        S_RESP
    } state_t;

    state_t     state_q, state_d;
    logic       sync1_q, as_s_q;
    logic [3:0] cnt_q, cnt_d;
    logic       auto_q, auto_d;
    logic [6:0] iack_q, iack_d;
    logic       vpa_q, vpa_d;
    logic       dtack_q, dtack_d;
    logic       oe_q, oe_d;
    logic [7:0] vec_q, vec_d;

    logic       is_iack;
    logic [6:0] lvl_1h;
    logic       spurious;
    logic       autovec;

    // One-hot of the acknowledged level (bit i = level i+1); all zero for addr_lo == 0.
    assign lvl_1h   = 7'((8'd1 << addr_lo_i) >> 1);
    assign is_iack  = (fc_i == 3'b111) && (addr_hi_i == 4'hF) && (addr_lo_i != 3'd0);
    assign spurious = (irq_n_i & lvl_1h) != 7'd0;
    assign autovec  = !spurious && ((AUTOVEC_MASK & lvl_1h) != 7'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        auto_d  = auto_q;
        iack_d  = iack_q;
        vpa_d   = vpa_q;
        dtack_d = dtack_q;
        oe_d    = oe_q;
        vec_d   = vec_q;
        unique case (state_q)
            S_IDLE: begin
                if (!as_s_q) begin
                    if (is_iack) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                        auto_d  = autovec;
                        iack_d  = ~lvl_1h;
                        if (spurious)
                            vec_d = 8'h18;
                        else if (autovec)
                            vec_d = 8'h00;
                        else
                            vec_d = VECTOR_BASE + {5'd0, addr_lo_i};
                    end else begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (as_s_q)
                    state_d = S_IDLE;
            end
            S_WAIT: begin
                // A released strobe wins over an expiring counter: the CPU has abandoned the cycle.
                if (as_s_q) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                    iack_d  = 7'h7F;
                    vpa_d   = 1'b1;
                    dtack_d = 1'b1;
                    oe_d    = 1'b0;
                    vec_d   = 8'h00;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    vpa_d   = !auto_q;
                    dtack_d = auto_q;
                    oe_d    = !auto_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (as_s_q) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                    iack_d  = 7'h7F;
                    vpa_d   = 1'b1;
                    dtack_d = 1'b1;
                    oe_d    = 1'b0;
                    vec_d   = 8'h00;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            as_s_q  <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            auto_q  <= 1'b0;
            iack_q  <= 7'h7F;
            vpa_q   <= 1'b1;
            dtack_q <= 1'b1;
            oe_q    <= 1'b0;
            vec_q   <= 8'h00;
        end else begin
            sync1_q <= as_n_i;
            as_s_q  <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            auto_q  <= auto_d;
            iack_q  <= iack_d;
            vpa_q   <= vpa_d;
            dtack_q <= dtack_d;
            oe_q    <= oe_d;
            vec_q   <= vec_d;
        end
    end

    assign iack_n_o  = iack_q;
    assign vpa_n_o   = vpa_q;
    assign dtack_n_o = dtack_q;
    assign vec_out_o = vec_q;
    assign vec_oe_o  = oe_q;

endmodule

// File: tb/tb_interrupt_ack_responder.sv
// Scoreboard bench: two responder instances (mixed autovector mask / 2 waits, all vectored / 0 waits)
// share one CPU bus; expected iack and response events are queued at issue time and popped by a monitor.
module tb_interrupt_ack_responder;

    localparam logic [6:0] MASK_A = 7'b1001011;
    localparam int         W_A    = 2;
    localparam int         W_B    = 0;

    typedef struct {
        int         cyc;
        logic [6:0] iack;
        logic       vpa;
        logic       dtack;
        logic       oe;
        logic [7:0] vec;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       as_n = 1'b1;
    logic [2:0] fc = 3'd0;
    logic [3:0] hi = 4'd0;
    logic [2:0] lo = 3'd0;
    logic [6:0] irq = 7'h7F;

    logic [6:0] iack_w [2];
    logic       vpa_w  [2];
    logic       dtack_w[2];
    logic [7:0] vec_w  [2];
    logic       oe_w   [2];

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t qi0[$], qi1[$], qr0[$], qr1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    interrupt_ack_responder #(.AUTOVEC_MASK(MASK_A), .VECTOR_BASE(8'h40), .WAIT_CYCLES(W_A)) dut_a (
        .clk(clk), .rst(rst), .as_n_i(as_n), .fc_i(fc), .addr_hi_i(hi), .addr_lo_i(lo), .irq_n_i(irq),
        .iack_n_o(iack_w[0]), .vpa_n_o(vpa_w[0]), .dtack_n_o(dtack_w[0]), .vec_out_o(vec_w[0]), .vec_oe_o(oe_w[0]));

    interrupt_ack_responder #(.AUTOVEC_MASK(7'h00), .VECTOR_BASE(8'h40), .WAIT_CYCLES(W_B)) dut_b (
        .clk(clk), .rst(rst), .as_n_i(as_n), .fc_i(fc), .addr_hi_i(hi), .addr_lo_i(lo), .irq_n_i(irq),
        .iack_n_o(iack_w[1]), .vpa_n_o(vpa_w[1]), .dtack_n_o(dtack_w[1]), .vec_out_o(vec_w[1]), .vec_oe_o(oe_w[1]));

    task automatic cmp(input string nm, input int d, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s dut%0d at cycle %0d: got %h expected %h", nm, d, cyc, act, req);
        end
    endtask

    function automatic logic [6:0] mask_of(input int d);
        return (d == 0) ? MASK_A : 7'h00;
    endfunction

    function automatic int wait_of(input int d);
        return (d == 0) ? W_A : W_B;
    endfunction

    // Reference: what the CPU should see for level lvl given the request lines at decode time.
    function automatic exp_t model(input int d, input int lvl, input logic [6:0] irq_at, input int t_fall, input bit resp);
        exp_t e;
        logic [6:0] m;
        bit requesting, use_auto;
        m          = mask_of(d);
        requesting = (irq_at[lvl-1] == 1'b0);
        use_auto   = requesting && m[lvl-1];
        e.iack     = 7'h7F & ~(7'd1 << (lvl - 1));
        e.vec      = !requesting ? 8'h18 : 8'((8'h40 + lvl) % 256);
        if (resp) begin
            e.cyc   = t_fall + 4 + wait_of(d);
            e.vpa   = !use_auto;
            e.dtack = use_auto;
            e.oe    = !use_auto;
        end else begin
            e.cyc   = t_fall + 3;
            e.vpa   = 1'b1;
            e.dtack = 1'b1;
            e.oe    = !use_auto;
        end
        return e;
    endfunction

    function automatic bit pop_exp(input int d, input bit resp, output exp_t e);
        e = '{cyc: 0, iack: 7'h7F, vpa: 1'b1, dtack: 1'b1, oe: 1'b0, vec: 8'h00};
        if (d == 0 && !resp && qi0.size() > 0) begin e = qi0.pop_front(); return 1'b1; end
        if (d == 1 && !resp && qi1.size() > 0) begin e = qi1.pop_front(); return 1'b1; end
        if (d == 0 && resp && qr0.size() > 0) begin e = qr0.pop_front(); return 1'b1; end
        if (d == 1 && resp && qr1.size() > 0) begin e = qr1.pop_front(); return 1'b1; end
        return 1'b0;
    endfunction

    function automatic int pending(input int d);
        return (d == 0) ? qi0.size() + qr0.size() : qi1.size() + qr1.size();
    endfunction

    // Monitor: pops on every iack assertion and every vpa_n/dtack_n assertion.
    logic [6:0] prev_iack [2] = '{7'h7F, 7'h7F};
    logic       prev_vpa  [2] = '{1'b1, 1'b1};
    logic       prev_dtack[2] = '{1'b1, 1'b1};

    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                if (iack_w[d] != 7'h7F)
                    cmp("iack_onehot", d, $countones(~iack_w[d]), 1);
                if (prev_iack[d] == 7'h7F && iack_w[d] != 7'h7F) begin
                    ok = pop_exp(d, 1'b0, e);
                    if (!ok) begin
                        cmp("unexpected_iack", d, iack_w[d], 7'h7F);
                    end else begin
                        cmp("iack_time", d, cyc, e.cyc);
                        cmp("iack_val", d, iack_w[d], e.iack);
                        if (e.oe) cmp("iack_vec", d, vec_w[d], e.vec);
                    end
                end
                if ((prev_vpa[d] && !vpa_w[d]) || (prev_dtack[d] && !dtack_w[d])) begin
                    ok = pop_exp(d, 1'b1, e);
                    if (!ok) begin
                        cmp("unexpected_resp", d, {vpa_w[d], dtack_w[d]}, 2'b11);
                    end else begin
                        cmp("resp_time", d, cyc, e.cyc);
                        cmp("resp_vpa", d, vpa_w[d], e.vpa);
                        cmp("resp_dtack", d, dtack_w[d], e.dtack);
                        cmp("resp_oe", d, oe_w[d], e.oe);
                        cmp("resp_iack", d, iack_w[d], e.iack);
                        if (e.oe) cmp("resp_vec", d, vec_w[d], e.vec);
                    end
                end
            end
            prev_iack[d]  = iack_w[d];
            prev_vpa[d]   = vpa_w[d];
            prev_dtack[d] = dtack_w[d];
        end
    end

    task automatic chk_idle(input string nm);
        for (int d = 0; d < 2; d++) begin
            cmp({nm, "_iack"}, d, iack_w[d], 7'h7F);
            cmp({nm, "_vpa"}, d, vpa_w[d], 1'b1);
            cmp({nm, "_dtack"}, d, dtack_w[d], 1'b1);
            cmp({nm, "_vec"}, d, vec_w[d], 8'h00);
            cmp({nm, "_oe"}, d, oe_w[d], 1'b0);
        end
    endtask

    // One bus cycle: as_n low for 'hold' clocks; optional irq_n churn after the decode edge.
    task automatic txn(input logic [2:0] f, input logic [3:0] h, input logic [2:0] l,
                       input logic [6:0] ir, input int hold, input bit scr);
        int   t_fall;
        bit   ack;
        exp_t e;
        @(negedge clk);
        fc = f; hi = h; lo = l; irq = ir; as_n = 1'b0;
        t_fall = cyc;
        ack = (f == 3'd7) && (h == 4'hF) && (l != 3'd0);
        if (ack) begin
            for (int d = 0; d < 2; d++) begin
                e = model(d, int'(l), ir, t_fall, 1'b0);
                if (d == 0) qi0.push_back(e); else qi1.push_back(e);
                if (hold > wait_of(d) + 1) begin
                    e = model(d, int'(l), ir, t_fall, 1'b1);
                    if (d == 0) qr0.push_back(e); else qr1.push_back(e);
                end
            end
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (scr && cyc >= t_fall + 3) irq = 7'($urandom);
        end
        as_n = 1'b1;
        repeat (2) @(negedge clk);
        if (ack)
            for (int d = 0; d < 2; d++) begin
                e = model(d, int'(l), ir, t_fall, 1'b0);
                cmp("iack_held", d, iack_w[d], e.iack);
            end
        @(negedge clk);
        chk_idle("release");
        for (int d = 0; d < 2; d++) cmp("missing_event", d, pending(d), 0);
    endtask

    initial begin
        int   t_fall;
        exp_t e;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        txn(3'd7, 4'hF, 3'd7, 7'b0111111, 12, 1'b0);   // level 7: autovector on A, vector 0x47 on B
        txn(3'd7, 4'hF, 3'd5, 7'b1101111, 8, 1'b0);    // level 5 vectored 0x45
        txn(3'd7, 4'hF, 3'd2, 7'h7F, 8, 1'b0);         // spurious level 2
        txn(3'd5, 4'hF, 3'd3, 7'h00, 10, 1'b0);        // user data space, not IACK
        txn(3'd7, 4'h2, 3'd3, 7'h00, 10, 1'b0);        // other CPU-space type
        txn(3'd7, 4'hF, 3'd0, 7'h00, 10, 1'b0);        // level 0 is not an acknowledge
        for (int h = 1; h <= 4; h++)
            txn(3'd7, 4'hF, 3'd4, 7'h00, h, 1'b0);     // abort / complete boundaries for both waits

        // Reset while both instances are responding to a vectored level 3.
        @(negedge clk);
        fc = 3'd7; hi = 4'hF; lo = 3'd3; irq = 7'b1111011; as_n = 1'b0;
        t_fall = cyc;
        for (int d = 0; d < 2; d++) begin
            e = model(d, 3, irq, t_fall, 1'b0);
            if (d == 0) qi0.push_back(e); else qi1.push_back(e);
            e = model(d, 3, irq, t_fall, 1'b1);
            if (d == 0) qr0.push_back(e); else qr1.push_back(e);
        end
        repeat (8) @(negedge clk);
        for (int d = 0; d < 2; d++) cmp("pre_reset_dtack", d, dtack_w[d], 1'b0);
        #2 rst = 1'b1;
        #1 chk_idle("async_reset");
        for (int d = 0; d < 2; d++) cmp("missing_event", d, pending(d), 0);
        @(negedge clk);
        as_n = 1'b1;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int n = 0; n < 80; n++) begin
            logic [2:0] f;
            logic [3:0] h;
            f = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd7;
            h = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            txn(f, h, 3'($urandom), 7'($urandom), $urandom_range(1, 7), 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
